fan_pwm_ctrl: RTL and testbench

FAN_PWM_CTRL -- requirements
Module: fan_pwm_ctrl

---
 rtl/fan_pkg.sv | 7 +
 rtl/pwm_gen.sv | 24 ++
 rtl/fan_pwm_ctrl.sv | 64 ++++++
 tb/tb_fan_pwm_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// fan_pkg: FSM state encoding and width helper shared by the fan PWM controller.
package fan_pkg;
   typedef enum logic [1:0] {S_OFF = 2'd0, S_RAMP = 2'd1, S_RUN = 2'd2} state_t;
   function automatic int clog2_min1(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM with duty latched only at the start of each period.
module pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [PWM_BITS-1:0] i_duty,
   output logic                o_pwm
);
   localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((2 ** PWM_BITS) - 2);
   logic [PWM_BITS-1:0] cnt;
   logic [PWM_BITS-1:0] duty;
   // period is 2^PWM_BITS-1 so full-scale duty yields a constant high output
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         cnt   <= '0;
         duty  <= '0;
         o_pwm <= 1'b0;
      end else begin
         cnt   <= (cnt == CNT_MAX) ? '0 : cnt + PWM_BITS'(1);
         duty  <= (cnt == '0) ? i_duty : duty;
         o_pwm <= cnt < duty;
      end
endmodule

// File: rtl/fan_pwm_ctrl.sv
// fan_pwm_ctrl: fan speed controller that ramps one level per RAMP_DIV clocks
// toward the requested level and drives the fan through pwm_gen.
module fan_pwm_ctrl
   import fan_pkg::*;
#(
   parameter int NUM_LEVELS = 4,
   parameter int PWM_BITS   = 8,
   parameter int DUTY_STEP  = 85,
   parameter int RAMP_DIV   = 100000,
   localparam int LVL_W     = clog2_min1(NUM_LEVELS)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_FANOnOff,
   input  logic [LVL_W-1:0] i_level,
   output logic             o_fan,
   output logic [LVL_W-1:0] o_cur_level,
   output logic             o_busy
);
   localparam int RC_W = clog2_min1(RAMP_DIV);
   localparam int unsigned MAX_LVL = NUM_LEVELS - 1;
   localparam logic [RC_W-1:0] RC_MAX = RC_W'(RAMP_DIV - 1);
   state_t           state, next_state;
   logic [LVL_W-1:0] cur_level, next_level, target, step_level;
   logic [RC_W-1:0]  rcnt, next_rcnt;
   assign target = !i_FANOnOff ? '0 : (32'(i_level) > MAX_LVL) ? LVL_W'(MAX_LVL) : i_level;
   assign step_level = (target > cur_level) ? cur_level + LVL_W'(1) : cur_level - LVL_W'(1);
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         state     <= S_OFF;
         cur_level <= '0;
         rcnt      <= '0;
      end else begin
         state     <= next_state;
         cur_level <= next_level;
         rcnt      <= next_rcnt;
      end
   // direction is recomputed at every step, so a target change mid-ramp reverses without restarting the count
   always_comb begin
      next_state = state;
      next_level = cur_level;
      next_rcnt  = '0;
      case (state)
         S_OFF: begin
            next_level = '0;
            if (target != '0) next_state = S_RAMP;
         end
         S_RUN: if (target != cur_level) next_state = S_RAMP;
         S_RAMP:
            if (target == cur_level) next_state = (target == '0) ? S_OFF : S_RUN;
            else if (rcnt == RC_MAX) next_level = step_level;
            else next_rcnt = rcnt + RC_W'(1);
         default: next_state = S_OFF;
      endcase
   end
   pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_duty (PWM_BITS'(32'(cur_level) * DUTY_STEP)),
      .o_pwm  (o_fan)
   );
   assign o_busy      = state == S_RAMP;
   assign o_cur_level = cur_level;
endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// tb_fan_pwm_ctrl: scoreboard bench comparing the controller against a level/phase reference model.
module tb_fan_pwm_ctrl;
   localparam int NL = 4, PB = 4, DS = 5, RD = 4;
   localparam int PERIOD = (1 << PB) - 1;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fan_on = 1'b0;
   logic [1:0] level = 2'd3;
   logic       fan, busy;
   logic [1:0] cur;
   typedef struct {int fan; int lvl; int busy;} exp_t;
   exp_t sb[$];
   int total = 0, bad = 0;
   int m_lvl = 0, m_busy = 0, m_phase = 0, m_pos = 0, m_duty = 0, m_fan = 0;

   fan_pwm_ctrl #(.NUM_LEVELS(NL), .PWM_BITS(PB), .DUTY_STEP(DS), .RAMP_DIV(RD)) dut (
      .i_clk(clk), .i_reset(rst), .i_FANOnOff(fan_on), .i_level(level),
      .o_fan(fan), .o_cur_level(cur), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference: ramp one level every RD clocks toward target; duty sampled per PWM period
   task automatic model_step(input int on, input int lv, input int r);
      int tgt;
      if (r != 0) begin
         m_lvl = 0; m_busy = 0; m_phase = 0; m_pos = 0; m_duty = 0; m_fan = 0;
         return;
      end
      tgt = (on == 0) ? 0 : (lv > NL - 1 ? NL - 1 : lv);
      m_fan = (m_pos < m_duty) ? 1 : 0;
      if (m_pos == 0) m_duty = m_lvl * DS;
      m_pos = (m_pos + 1) % PERIOD;
      if (m_busy == 0) begin
         if (tgt != m_lvl) begin m_busy = 1; m_phase = 0; end
      end else if (tgt == m_lvl) begin
         m_busy = 0; m_phase = 0;
      end else begin
         m_phase++;
         if (m_phase == RD) begin
            m_phase = 0;
            m_lvl += (tgt > m_lvl) ? 1 : -1;
         end
      end
   endtask

   task automatic tick();
      int on, lv, r;
      exp_t e;
      on = int'(fan_on); lv = int'(level); r = int'(rst);
      @(posedge clk);
      #1;
      model_step(on, lv, r);
      e.fan = m_fan; e.lvl = m_lvl; e.busy = m_busy;
      sb.push_back(e);
   endtask

   task automatic run_until(input int l, input int want_busy, input int budget, input string tag);
      int n = 0;
      while (!(m_lvl == l && (want_busy < 0 || m_busy == want_busy)) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         total++; bad++;
         $display("FAIL %s timeout actual_lvl=%0d expected_lvl=%0d", tag, m_lvl, l);
      end
   endtask

   task automatic count_high(input int n, output int h);
      h = 0;
      repeat (n) begin
         tick();
         h += int'(fan);
      end
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check({tag, "_fan"}, int'(fan), 0);
      check({tag, "_lvl"}, int'(cur), 0);
      check({tag, "_busy"}, int'(busy), 0);
      repeat (2) tick();
      rst = 1'b0;
   endtask

   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("sb_fan", int'(fan), e.fan);
         check("sb_lvl", int'(cur), e.lvl);
         check("sb_busy", int'(busy), e.busy);
      end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int h;
      repeat (2) tick();
      rst = 1'b0;
      repeat (100) tick();
      fan_on = 1'b1; level = 2'd3;
      run_until(3, 0, 60, "ramp_up");
      repeat (30) tick();
      count_high(PERIOD, h);
      check("full_duty_highs", h, 15);
      level = 2'd1;
      run_until(1, 0, 60, "ramp_down");
      repeat (30) tick();
      count_high(PERIOD, h);
      check("low_duty_highs", h, 5);
      fan_on = 1'b0;
      run_until(0, 0, 60, "to_off");
      repeat (20) tick();
      fan_on = 1'b1; level = 2'd3;
      run_until(2, 1, 60, "mid_ramp_a");
      fan_on = 1'b0;
      run_until(0, 0, 60, "abort_off");
      repeat (20) tick();
      count_high(PERIOD, h);
      check("off_highs", h, 0);
      fan_on = 1'b1; level = 2'd3;
      run_until(2, 1, 60, "mid_ramp_b");
      tick();
      level = 2'd1;
      run_until(1, 0, 60, "reversal");
      level = 2'd3;
      run_until(2, 1, 60, "mid_ramp_c");
      tick();
      async_reset("rst_mid");
      run_until(3, 0, 60, "restart");
      repeat (1500) begin
         if ($urandom_range(0, 11) == 0) begin
            fan_on = 1'($urandom_range(0, 3) != 0);
            level  = 2'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 299) == 0) async_reset("rst_rand");
         tick();
      end
      @(negedge clk);
      #1;
      check("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
